instruction_encoder: RTL and testbench
======================================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be as listed below, clock and reset first.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  request valid; in_ready  out  1  request accepted when in_valid&in_ready.
REQ-005 in_op  in  5  mnemonic: 0 ADD, 1 SUB, 2 SLT, 3 JR, 4 MULT, 5 MFHI, 6 MFLO, 7 LW, 8 SW, 9 BEQ, 10 BNE, 11 ADDI, 12 XORI, 13 J, 14 JAL, 16 ADD.S, 17 SUB.S, 18 LWC1, 19 SWC1; all others illegal.
REQ-006 in_rs, in_rt, in_rd  in  5 each  register fields; in_imm  in  16; in_target  in  26.
REQ-007 addr_load  in  1; addr_value  in  32  new write byte address.
REQ-008 im_we  out  1  write request; im_addr  out  32; im_wdata  out  32; im_ack  in  1  memory accepts the write when im_we&im_ack.
REQ-009 count  out  3  FIFO occupancy 0..4; err  out  1  sticky illegal-op flag; err_clr  in  1.

Function
REQ-010 An accepted legal request SHALL be encoded and pushed into a 4-entry FIFO on the same edge; im_we SHALL rise on the following cycle if the FIFO was empty.
REQ-011 R-type encodings SHALL be {6'h00, rs, rt, rd, 5'b0, funct} with funct ADD 0x20, SUB 0x22, SLT 0x2a, JR 0x08, MULT 0x18, MFHI 0x10, MFLO 0x12.
REQ-012 Field zeroing: JR SHALL force rt=rd=0; MULT SHALL force rd=0; MFHI and MFLO SHALL force rs=rt=0.
REQ-013 I-type encodings SHALL be {opcode, rs, rt, imm} with LW 0x23, SW 0x2b, BEQ 0x04, BNE 0x05, ADDI 0x08, XORI 0x0e, LWC1 0x31, SWC1 0x39.
REQ-014 J (0x02) and JAL (0x03) SHALL encode as {opcode, target}.
REQ-015 ADD.S and SUB.S SHALL encode as {6'h11, 5'h10, ft=in_rt, fs=in_rs, fd=in_rd, funct}, with funct ADD.S 0x00 and SUB.S 0x01.
REQ-016 in_ready SHALL equal (count != 4); a pop in the same cycle SHALL NOT make a full FIFO ready.
REQ-017 im_we SHALL equal (count != 0) and im_wdata SHALL be the FIFO head.
REQ-018 On im_we&im_ack the head SHALL be popped and im_addr SHALL advance by 4, wrapping modulo 2^32.
REQ-019 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-020 addr_load SHALL load im_addr with {addr_value[31:2], 2'b00} and SHALL take priority over the increment in the same cycle.
REQ-021 An accepted illegal in_op SHALL complete the handshake, push nothing and set err on the next edge.
REQ-022 err_clr SHALL clear err; if an illegal op is accepted in the same cycle, the set SHALL take priority.
REQ-023 im_wdata and im_addr SHALL remain stable while im_we=1 and im_ack=0.

Reset
REQ-024 On rst_n low the following SHALL apply immediately:
- count=0, im_we=0, im_addr=0, im_wdata=0, err=0;
- in_ready=1 after rst_n deasserts.
REQ-025 Reset asserted mid-operation SHALL discard all queued words, and no write SHALL be issued for them.

Configuration
REQ-026 With macro FPU_INSTR_EN defined, ops 16-19 SHALL encode per REQ-013 and REQ-015.
REQ-027 Without FPU_INSTR_EN, ops 16-19 SHALL be treated as illegal per REQ-021.

Verification
REQ-028 ADD with rs=1, rt=2, rd=3, im_ack=1 -> one cycle later im_we=1, im_wdata=0x00221820, im_addr=0; then im_addr=4.
REQ-029 ADDI rt=8, rs=0, imm=0x0005, then JAL target=0x10 -> im_wdata=0x20080005 then 0x0C000010, at consecutive addresses.
REQ-030 FPU_INSTR_EN defined, ADD.S fd=3, fs=1, ft=2 -> im_wdata=0x460208C0; without the macro -> err=1 and count=0.
REQ-031 Five back-to-back requests with im_ack=0 -> count=4 and in_ready=0 after four; the fifth is held; raising im_ack drains the FIFO in order.
REQ-032 in_op=25 -> err=1 and count unchanged; err_clr -> err=0.
REQ-033 addr_value=0xFFFFFFFC loaded, two writes -> im_addr=0xFFFFFFFC then 0x00000000; rst_n pulse with 3 words queued -> count=0 and im_we=0 immediately.

Source files
------------

// File: rtl/instruction_encoder.sv
//------------------------------------------------------------------------------
// Module      : instruction_encoder
// Description : Encodes MIPS-style mnemonics into 32-bit words, queues them in
//               a 4-entry FIFO and writes them to sequential memory addresses.
//               Define FPU_INSTR_EN to enable ADD.S/SUB.S/LWC1/SWC1 (ops 16-19).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instruction_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    input  logic        addr_load,
    input  logic [31:0] addr_value,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    input  logic        im_ack,
    output logic [2:0]  count,
    output logic        err,
    input  logic        err_clr
);

    localparam logic [4:0] c_op_add   = 5'd0;
    localparam logic [4:0] c_op_sub   = 5'd1;
    localparam logic [4:0] c_op_slt   = 5'd2;
    localparam logic [4:0] c_op_jr    = 5'd3;
    localparam logic [4:0] c_op_mult  = 5'd4;
    localparam logic [4:0] c_op_mfhi  = 5'd5;
    localparam logic [4:0] c_op_mflo  = 5'd6;
    localparam logic [4:0] c_op_lw    = 5'd7;
    localparam logic [4:0] c_op_sw    = 5'd8;
    localparam logic [4:0] c_op_beq   = 5'd9;
    localparam logic [4:0] c_op_bne   = 5'd10;
    localparam logic [4:0] c_op_addi  = 5'd11;
    localparam logic [4:0] c_op_xori  = 5'd12;
    localparam logic [4:0] c_op_j     = 5'd13;
    localparam logic [4:0] c_op_jal   = 5'd14;
`ifdef FPU_INSTR_EN
    localparam logic [4:0] c_op_adds  = 5'd16;
    localparam logic [4:0] c_op_subs  = 5'd17;
    localparam logic [4:0] c_op_lwc1  = 5'd18;
    localparam logic [4:0] c_op_swc1  = 5'd19;
`endif
    localparam logic [2:0] c_depth    = 3'd4;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    logic        w_legal;
    logic [31:0] w_word;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    logic [31:0] r_mem [0:3];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    logic [31:0] r_addr;
    logic        r_err;

    always_comb begin
        w_legal = 1'b1;
        w_word  = 32'h0000_0000;
        case (in_op)
            c_op_add:  w_word = rtype(in_rs, in_rt, in_rd, 6'h20);
            c_op_sub:  w_word = rtype(in_rs, in_rt, in_rd, 6'h22);
            c_op_slt:  w_word = rtype(in_rs, in_rt, in_rd, 6'h2a);
            c_op_jr:   w_word = rtype(in_rs, 5'd0, 5'd0, 6'h08);
            c_op_mult: w_word = rtype(in_rs, in_rt, 5'd0, 6'h18);
            c_op_mfhi: w_word = rtype(5'd0, 5'd0, in_rd, 6'h10);
            c_op_mflo: w_word = rtype(5'd0, 5'd0, in_rd, 6'h12);
            c_op_lw:   w_word = itype(6'h23, in_rs, in_rt, in_imm);
            c_op_sw:   w_word = itype(6'h2b, in_rs, in_rt, in_imm);
            c_op_beq:  w_word = itype(6'h04, in_rs, in_rt, in_imm);
            c_op_bne:  w_word = itype(6'h05, in_rs, in_rt, in_imm);
            c_op_addi: w_word = itype(6'h08, in_rs, in_rt, in_imm);
            c_op_xori: w_word = itype(6'h0e, in_rs, in_rt, in_imm);
            c_op_j:    w_word = {6'h02, in_target};
            c_op_jal:  w_word = {6'h03, in_target};
`ifdef FPU_INSTR_EN
            // COP1 format: ft comes from in_rt, fs from in_rs, fd from in_rd
            c_op_adds: w_word = {6'h11, 5'h10, in_rt, in_rs, in_rd, 6'h00};
            c_op_subs: w_word = {6'h11, 5'h10, in_rt, in_rs, in_rd, 6'h01};
            c_op_lwc1: w_word = itype(6'h31, in_rs, in_rt, in_imm);
            c_op_swc1: w_word = itype(6'h39, in_rs, in_rt, in_imm);
`endif
            default:   w_legal = 1'b0;
        endcase
    end

    assign in_ready = (r_count != c_depth);
    assign w_accept = in_valid & in_ready;
    assign w_push   = w_accept & w_legal;
    assign im_we    = (r_count != 3'd0);
    assign w_pop    = im_we & im_ack;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 3'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= 32'h0000_0000;
        end else if (addr_load) begin
            r_addr <= {addr_value[31:2], 2'b00};
        end else if (w_pop) begin
            r_addr <= r_addr + 32'd4;
        end
    end

    // Setting on an illegal accept outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_legal) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    // Empty FIFO drives zero so stale entries never appear on the bus
    assign im_wdata = im_we ? r_mem[r_rd_ptr] : 32'h0000_0000;
    assign im_addr  = r_addr;
    assign count    = r_count;
    assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instruction_encoder.sv
//------------------------------------------------------------------------------
// Module      : tb_instruction_encoder
// Description : Directed self-checking bench for instruction_encoder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instruction_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        addr_load;
    logic [31:0] addr_value;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        im_ack;
    logic [2:0]  count;
    logic        err;
    logic        err_clr;

    int total;
    int bad;

    instruction_encoder u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .addr_load  (addr_load),
        .addr_value (addr_value),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .im_ack     (im_ack),
        .count      (count),
        .err        (err),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        in_op     = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_target = tgt;
        in_valid  = 1'b1;
    endtask

    // One request with an idle FIFO and im_ack high: word appears, then is written
    task automatic encode_one(input string tag, input logic [4:0] op, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd,
                              input logic [15:0] imm, input logic [25:0] tgt,
                              input logic [31:0] exp);
        set_req(op, rs, rt, rd, imm, tgt);
        tick();
        in_valid = 1'b0;
        check(tag, im_wdata, exp);
        tick();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_op      = 5'd0;
        in_rs      = 5'd0;
        in_rt      = 5'd0;
        in_rd      = 5'd0;
        in_imm     = 16'h0;
        in_target  = 26'h0;
        addr_load  = 1'b0;
        addr_value = 32'h0;
        im_ack     = 1'b0;
        err_clr    = 1'b0;

        #12;
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_we", {31'd0, im_we}, 32'd0);
        check("rst_addr", im_addr, 32'h0);
        check("rst_wdata", im_wdata, 32'h0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", {31'd0, in_ready}, 32'd1);

        // ADD 1,2,3 with im_ack high
        im_ack = 1'b1;
        set_req(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        in_valid = 1'b0;
        check("add_we", {31'd0, im_we}, 32'd1);
        check("add_wdata", im_wdata, 32'h0022_1820);
        check("add_addr", im_addr, 32'h0);
        tick();
        check("add_addr_next", im_addr, 32'h4);
        check("add_count", {29'd0, count}, 32'd0);

        // ADDI then JAL at consecutive addresses; stable while not acked
        im_ack = 1'b0;
        set_req(5'd11, 5'd0, 5'd8, 5'd0, 16'h0005, 26'h0);
        tick();
        set_req(5'd14, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
        tick();
        in_valid = 1'b0;
        check("seq_count", {29'd0, count}, 32'd2);
        tick();
        check("seq_hold_wdata", im_wdata, 32'h2008_0005);
        check("seq_hold_addr", im_addr, 32'h4);
        im_ack = 1'b1;
        tick();
        check("seq_wdata2", im_wdata, 32'h0C00_0010);
        check("seq_addr2", im_addr, 32'h8);
        tick();
        check("seq_drained", {29'd0, count}, 32'd0);
        check("seq_addr3", im_addr, 32'hC);

        // Remaining encodings, including field zeroing
        encode_one("sub",  5'd1,  5'd1,  5'd2,  5'd3, 16'h0,    26'h0,       32'h0022_1822);
        encode_one("slt",  5'd2,  5'd1,  5'd2,  5'd3, 16'h0,    26'h0,       32'h0022_182a);
        encode_one("jr",   5'd3,  5'd5,  5'd6,  5'd7, 16'h0,    26'h0,       32'h00A0_0008);
        encode_one("mult", 5'd4,  5'd1,  5'd2,  5'd3, 16'h0,    26'h0,       32'h0022_0018);
        encode_one("mfhi", 5'd5,  5'd1,  5'd2,  5'd3, 16'h0,    26'h0,       32'h0000_1810);
        encode_one("mflo", 5'd6,  5'd1,  5'd2,  5'd3, 16'h0,    26'h0,       32'h0000_1812);
        encode_one("lw",   5'd7,  5'd29, 5'd8,  5'd0, 16'hFFFC, 26'h0,       32'h8FA8_FFFC);
        encode_one("sw",   5'd8,  5'd29, 5'd8,  5'd0, 16'h0004, 26'h0,       32'hAFA8_0004);
        encode_one("beq",  5'd9,  5'd1,  5'd2,  5'd0, 16'h0010, 26'h0,       32'h1022_0010);
        encode_one("bne",  5'd10, 5'd1,  5'd2,  5'd0, 16'h0010, 26'h0,       32'h1422_0010);
        encode_one("xori", 5'd12, 5'd3,  5'd4,  5'd0, 16'hABCD, 26'h0,       32'h3864_ABCD);
        encode_one("j",    5'd13, 5'd0,  5'd0,  5'd0, 16'h0,    26'h3FFFFFF, 32'h0BFF_FFFF);
        check("tbl_addr", im_addr, 32'h3C);

        // ADD.S fd=3 fs=1 ft=2
        set_req(5'd16, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        in_valid = 1'b0;
`ifdef FPU_INSTR_EN
        check("adds_wdata", im_wdata, 32'h4602_08C0);
        check("adds_err", {31'd0, err}, 32'd0);
        tick();
        encode_one("subs", 5'd17, 5'd1, 5'd2, 5'd3, 16'h0,  26'h0, 32'h4602_08C1);
        encode_one("lwc1", 5'd18, 5'd1, 5'd2, 5'd0, 16'h8,  26'h0, 32'hC422_0008);
        encode_one("swc1", 5'd19, 5'd1, 5'd2, 5'd0, 16'h8,  26'h0, 32'hE422_0008);
`else
        check("adds_err", {31'd0, err}, 32'd1);
        check("adds_count", {29'd0, count}, 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("adds_err_clr", {31'd0, err}, 32'd0);
`endif

        // Illegal op: err set, count unchanged, set beats clear
        im_ack = 1'b0;
        set_req(5'd11, 5'd0, 5'd1, 5'd0, 16'h00AA, 26'h0);
        tick();
        set_req(5'd25, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        tick();
        in_valid = 1'b0;
        check("ill_err", {31'd0, err}, 32'd1);
        check("ill_count", {29'd0, count}, 32'd1);
        set_req(5'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        err_clr = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ill_set_prio", {31'd0, err}, 32'd1);
        tick();
        err_clr = 1'b0;
        check("ill_clr", {31'd0, err}, 32'd0);
        im_ack = 1'b1;
        tick();
        im_ack = 1'b0;
        check("ill_drain", {29'd0, count}, 32'd0);

        // Five back-to-back requests against a stalled memory
        for (int i = 1; i <= 5; i++) begin
            set_req(5'd11, 5'd0, 5'd1, 5'd0, 16'(i), 26'h0);
            if (i <= 4) begin
                tick();
            end
        end
        check("full_count", {29'd0, count}, 32'd4);
        check("full_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("full_held", {29'd0, count}, 32'd4);
        im_ack = 1'b1;
        #1;
        check("full_pop_ready", {31'd0, in_ready}, 32'd0);
        check("drain_w1", im_wdata, 32'h2001_0001);
        tick();
        check("drain_w2", im_wdata, 32'h2001_0002);
        check("drain_cnt3", {29'd0, count}, 32'd3);
        tick();
        in_valid = 1'b0;
        check("pushpop_cnt", {29'd0, count}, 32'd3);
        for (int i = 3; i <= 5; i++) begin
            check($sformatf("drain_w%0d", i), im_wdata, 32'h2001_0000 | 32'(i));
            tick();
        end
        check("drain_empty", {29'd0, count}, 32'd0);

        // Address load, wrap, and load-over-increment priority
        im_ack     = 1'b0;
        addr_load  = 1'b1;
        addr_value = 32'hFFFF_FFFF;
        tick();
        addr_load = 1'b0;
        check("load_addr", im_addr, 32'hFFFF_FFFC);
        set_req(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        tick();
        in_valid = 1'b0;
        im_ack   = 1'b1;
        check("wrap_addr0", im_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr1", im_addr, 32'h0);
        tick();
        check("wrap_addr2", im_addr, 32'h4);
        im_ack = 1'b0;
        set_req(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        in_valid   = 1'b0;
        im_ack     = 1'b1;
        addr_load  = 1'b1;
        addr_value = 32'h0000_0100;
        tick();
        addr_load = 1'b0;
        im_ack    = 1'b0;
        check("load_prio", im_addr, 32'h100);
        check("load_prio_cnt", {29'd0, count}, 32'd0);

        // Reset mid-operation with three words queued
        for (int i = 0; i < 3; i++) begin
            set_req(5'd11, 5'd0, 5'd1, 5'd0, 16'(i), 26'h0);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_cnt", {29'd0, count}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", {29'd0, count}, 32'd0);
        check("mid_rst_we", {31'd0, im_we}, 32'd0);
        check("mid_rst_addr", im_addr, 32'h0);
        check("mid_rst_wdata", im_wdata, 32'h0);
        tick();
        rst_n  = 1'b1;
        im_ack = 1'b1;
        tick();
        tick();
        check("post_rst_we", {31'd0, im_we}, 32'd0);
        check("post_rst_addr", im_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
